// File: rtl/cycle_timing_ring_if.sv
// Console-side and gate-side signals of the cycle timing ring.
// The console drives the master modport, and the ring implements the slave modport.
interface cycle_timing_ring_if #(
    parameter int unsigned NUM_PHASES = 10,
    parameter int unsigned COUNT_W    = 8
);
    logic                  start;
    logic                  stop;
    logic                  single_cycle;
    logic [NUM_PHASES-1:0] phase_n;
    logic                  cycle_start;
    logic                  cycle_end;
    logic                  running;
    logic [COUNT_W-1:0]    cycle_count;

    modport master (
        output start, stop, single_cycle,
        input  phase_n, cycle_start, cycle_end, running, cycle_count
    );

    modport slave (
        input  start, stop, single_cycle,
        output phase_n, cycle_start, cycle_end, running, cycle_count
    );
endinterface

// File: rtl/cycle_timing_ring.sv
// Machine cycle timing generator. It produces one-hot, active-low phase gates,
// and supports start, continuous run, single-cycle and orderly stop.
module cycle_timing_ring #(
    parameter int unsigned TICKS_PER_PHASE = 2,
    parameter int unsigned NUM_PHASES      = 10,
    parameter int unsigned COUNT_W         = 8
) (
    input  logic                clk,
    input  logic                reset,
    cycle_timing_ring_if.slave  bus
);
    localparam int unsigned TICK_W  = (TICKS_PER_PHASE > 1) ? $clog2(TICKS_PER_PHASE) : 1;
    localparam int unsigned PHASE_W = $clog2(NUM_PHASES);

    localparam logic [TICK_W-1:0]     LAST_TICK  = TICK_W'(TICKS_PER_PHASE - 1);
    localparam logic [PHASE_W-1:0]    LAST_PHASE = PHASE_W'(NUM_PHASES - 1);
    localparam logic [NUM_PHASES-1:0] PHASE0_BIT = NUM_PHASES'(1);

    typedef enum logic {StIdle, StRun} state_e;

    state_e                state_q, state_d;
    logic [PHASE_W-1:0]    phase_q, phase_d;
    logic [TICK_W-1:0]     tick_q, tick_d;
    logic                  stop_pending_q, stop_pending_d;
    logic [COUNT_W-1:0]    count_q, count_d;
    logic [NUM_PHASES-1:0] phase_n_q, phase_n_d;
    logic                  cycle_start_q, cycle_start_d;
    logic                  cycle_end_q, cycle_end_d;
    logic                  running_q, running_d;

    always_comb begin
        state_d        = state_q;
        phase_d        = phase_q;
        tick_d         = tick_q;
        stop_pending_d = stop_pending_q;
        count_d        = count_q;

        unique case (state_q)
            StIdle: begin
                if (bus.start && !bus.stop) begin
                    state_d        = StRun;
                    phase_d        = '0;
                    tick_d         = '0;
                    stop_pending_d = 1'b0;
                end
            end
            StRun: begin
                if (bus.stop) stop_pending_d = 1'b1;
                if (tick_q == LAST_TICK) begin
                    tick_d = '0;
                    if (phase_q == LAST_PHASE) begin
                        count_d = count_q + 1'b1;
                        phase_d = '0;
                        // Stop requests take effect only here, so a cycle always completes.
                        if (bus.single_cycle || stop_pending_q || bus.stop) begin
                            state_d        = StIdle;
                            stop_pending_d = 1'b0;
                        end
                    end else begin
                        phase_d = phase_q + 1'b1;
                    end
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        // Outputs are decoded from next state so they are registered with it.
        running_d     = (state_d == StRun);
        phase_n_d     = running_d ? ~(PHASE0_BIT << phase_d) : '1;
        cycle_start_d = running_d && (phase_d == '0) && (tick_d == '0);
        cycle_end_d   = running_d && (phase_d == LAST_PHASE) && (tick_d == LAST_TICK);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= StIdle;
            phase_q        <= '0;
            tick_q         <= '0;
            stop_pending_q <= 1'b0;
            count_q        <= '0;
            phase_n_q      <= '1;
            cycle_start_q  <= 1'b0;
            cycle_end_q    <= 1'b0;
            running_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            phase_q        <= phase_d;
            tick_q         <= tick_d;
            stop_pending_q <= stop_pending_d;
            count_q        <= count_d;
            phase_n_q      <= phase_n_d;
            cycle_start_q  <= cycle_start_d;
            cycle_end_q    <= cycle_end_d;
            running_q      <= running_d;
        end
    end

    assign bus.phase_n     = phase_n_q;
    assign bus.cycle_start = cycle_start_q;
    assign bus.cycle_end   = cycle_end_q;
    assign bus.running     = running_q;
    assign bus.cycle_count = count_q;

    phase_onehot_a: assert property (@(posedge clk) disable iff (reset)
        $onehot0(~phase_n_q) && (running_q || (&phase_n_q)));
endmodule

// File: tb/tb_cycle_timing_ring.sv
// Directed bench for cycle_timing_ring. It compares {phase_n, cycle_start, cycle_end,
// running, cycle_count} against hand-derived expectations at each sampled clock.
module tb_cycle_timing_ring;
    localparam int unsigned TPP = 2;
    localparam int unsigned NP  = 10;
    localparam int unsigned CW  = 8;
    localparam int          L   = TPP * NP;

    typedef logic [NP+3+CW-1:0] obs_t;

    logic clk = 1'b0;
    logic reset;
    int   n_pass = 0;
    int   n_total = 0;

    cycle_timing_ring_if #(.NUM_PHASES(NP), .COUNT_W(CW)) bus ();

    cycle_timing_ring #(
        .TICKS_PER_PHASE(TPP),
        .NUM_PHASES     (NP),
        .COUNT_W        (CW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    function automatic obs_t observed();
        return {bus.phase_n, bus.cycle_start, bus.cycle_end, bus.running, bus.cycle_count};
    endfunction

    // Clock k of a continuous run whose first active clock is k=1.
    function automatic obs_t exp_run(int k);
        int m;
        logic [NP-1:0] ph;
        m  = (k - 1) % L;
        ph = ~(NP'(1) << (m / TPP));
        return {ph, (m == 0), (m == L - 1), 1'b1, CW'((k - 1) / L)};
    endfunction

    function automatic obs_t exp_idle(int cnt);
        return {{NP{1'b1}}, 3'b000, CW'(cnt)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.start = 1'b0;
        bus.stop = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    // Pulse start for one edge, and leave time at clk 1 of the run.
    task automatic start_pulse();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.start = 1'b1;
        bus.stop = 1'b0;
        bus.single_cycle = 1'b1;
        step();
        step();
        n_total++;
        if (observed() !== exp_idle(0))
            $display("FAIL reset_state: got %h expected %h", observed(), exp_idle(0));
        else n_pass++;
        bus.start = 1'b0;
        reset = 1'b0;
        step();
        n_total++;
        if (observed() !== exp_idle(0))
            $display("FAIL reset_release_idle: got %h expected %h", observed(), exp_idle(0));
        else n_pass++;
    endtask

    task automatic test_single_cycle();
        obs_t e;
        do_reset();
        bus.single_cycle = 1'b1;
        start_pulse();
        for (int k = 1; k <= 21; k++) begin
            e = (k <= 20) ? exp_run(k) : exp_idle(1);
            n_total++;
            if (observed() !== e)
                $display("FAIL single_cycle clk %0d: got %h expected %h", k, observed(), e);
            else n_pass++;
            step();
        end
        n_total++;
        if (observed() !== exp_idle(1))
            $display("FAIL single_cycle_stays_idle: got %h expected %h", observed(), exp_idle(1));
        else n_pass++;
    endtask

    task automatic test_continuous();
        do_reset();
        bus.single_cycle = 1'b0;
        start_pulse();
        for (int k = 1; k <= 61; k++) begin
            n_total++;
            if (observed() !== exp_run(k))
                $display("FAIL continuous clk %0d: got %h expected %h", k, observed(), exp_run(k));
            else n_pass++;
            if (k < 61) step();
        end
    endtask

    task automatic test_stop();
        obs_t e;
        do_reset();
        bus.single_cycle = 1'b0;
        start_pulse();
        for (int k = 2; k <= 9; k++) step();
        bus.stop = 1'b1;   // sampled during phase 4
        step();
        bus.stop = 1'b0;
        for (int k = 10; k <= 22; k++) begin
            e = (k <= 20) ? exp_run(k) : exp_idle(1);
            n_total++;
            if (observed() !== e)
                $display("FAIL stop_mid clk %0d: got %h expected %h", k, observed(), e);
            else n_pass++;
            step();
        end

        do_reset();
        start_pulse();
        for (int k = 2; k <= 20; k++) step();
        n_total++;
        if (observed() !== exp_run(20))
            $display("FAIL stop_at_end_pre: got %h expected %h", observed(), exp_run(20));
        else n_pass++;
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
        n_total++;
        if (observed() !== exp_idle(1))
            $display("FAIL stop_at_end: got %h expected %h", observed(), exp_idle(1));
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.single_cycle = 1'b0;
        start_pulse();
        for (int k = 2; k <= 25; k++) step();
        bus.stop = 1'b1;   // leaves a stop pending for reset to clear
        step();
        bus.stop = 1'b0;
        for (int k = 27; k <= 33; k++) step();
        n_total++;
        if (observed() !== exp_run(33))
            $display("FAIL reset_mid_phase6: got %h expected %h", observed(), exp_run(33));
        else n_pass++;
        reset = 1'b1;
        step();
        n_total++;
        if (observed() !== exp_idle(0))
            $display("FAIL reset_mid_idle: got %h expected %h", observed(), exp_idle(0));
        else n_pass++;
        reset = 1'b0;
        start_pulse();
        n_total++;
        if (observed() !== exp_run(1))
            $display("FAIL reset_mid_restart: got %h expected %h", observed(), exp_run(1));
        else n_pass++;
        for (int k = 2; k <= 21; k++) step();
        n_total++;
        if (observed() !== exp_run(21))
            $display("FAIL reset_mid_no_pending: got %h expected %h", observed(), exp_run(21));
        else n_pass++;
    endtask

    task automatic test_start_held();
        obs_t e;
        int   m;
        do_reset();
        bus.single_cycle = 1'b1;
        bus.start = 1'b1;
        bus.stop = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            n_total++;
            if (observed() !== exp_idle(0))
                $display("FAIL start_and_stop_idle %0d: got %h expected %h", i, observed(),
                         exp_idle(0));
            else n_pass++;
        end
        bus.stop = 1'b0;
        step();
        // A held start restarts one clk after each single cycle ends.
        for (int k = 1; k <= 42; k++) begin
            m = (k - 1) % (L + 1);
            if (m < L) begin
                e = exp_run(m + 1);
                e[CW-1:0] = CW'(k / (L + 1));
            end else begin
                e = exp_idle(k / (L + 1));
            end
            n_total++;
            if (observed() !== e)
                $display("FAIL start_held clk %0d: got %h expected %h", k, observed(), e);
            else n_pass++;
            step();
        end
        bus.start = 1'b0;
    endtask

    task automatic test_wrap();
        do_reset();
        bus.single_cycle = 1'b0;
        start_pulse();
        for (int k = 2; k <= 5101; k++) step();
        for (int k = 5101; k <= 5121; k++) begin
            bus.start = ((k % 3) == 0);   // start pulses mid-cycle must be ignored
            n_total++;
            if (observed() !== exp_run(k))
                $display("FAIL wrap clk %0d: got %h expected %h", k, observed(), exp_run(k));
            else n_pass++;
            step();
        end
        bus.start = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        bus.start = 1'b0;
        bus.stop = 1'b0;
        bus.single_cycle = 1'b0;
        test_reset();
        test_single_cycle();
        test_continuous();
        test_stop();
        test_reset_mid();
        test_start_held();
        test_wrap();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
